// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a hardware clear
// sequence after reset. Each read port owns a replicated bank so every bank
// stays single-read/single-write; all accepted writes go to every bank.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-low reset
//   rd_en    per-port read enable (bit k -> port k)
//   rd_addr  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data  packed registered read data, port k at [k*DATA_W +: DATA_W]
//   wr_en    write enable
//   wr_addr  write address
//   wr_data  write data
//   busy     high while the clear sequence runs (reads/writes ignored)
//
// Build option: define REGFILE_BYPASS_EN for write-first same-edge
// collisions; leave it undefined for read-first (no bypass mux).
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_q, busy_d;

  // Shared write port into all banks (clear writes or user writes)
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and bank write-port steering
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    busy_d      = busy_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = wr_addr;
    mem_wdata_c = wr_data;
    case (state_q)
      CLEAR: begin
        mem_we_c    = reset;
        mem_waddr_c = clr_ptr_q;
        mem_wdata_c = '0;
        clr_ptr_d   = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        busy_d   = 1'b0;
        // Writes to r0 are dropped when it is hardwired to zero
        mem_we_c = reset && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign busy = busy_q;

  // One bank plus one registered read port per read port
  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_port
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] rd_val_c;
    logic [DATA_W-1:0] rd_q;

    assign addr_c = rd_addr[k*ADDR_W +: ADDR_W];

    // Bank write (no reset on storage; cleared by the CLEAR sequence)
    always_ff @(posedge clk) begin
      if (mem_we_c) begin
        mem[mem_waddr_c] <= mem_wdata_c;
      end
    end

    // Read value selection; r0 forcing has priority over any bypass
    always_comb begin
      rd_val_c = mem[addr_c];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_addr == addr_c)) begin
        rd_val_c = wr_data;
      end
`endif
      if ((ZERO_REG != 0) && (addr_c == '0)) begin
        rd_val_c = '0;
      end
    end

    // Registered read data; holds when not enabled, zero through clear
    always_ff @(posedge clk) begin
      if (!reset) begin
        rd_q <= '0;
      end else if ((state_q == RUN) && rd_en[k]) begin
        rd_q <= rd_val_c;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: two instances sharing write/reset
// stimulus (A: 2 ports, r0 hardwired; B: 3 ports, r0 writable), checked each
// cycle against an array-based model plus a few literal expectations.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  rd_en_a = '0;
  logic [9:0]  rd_addr_a = '0;
  logic [63:0] rd_data_a;
  logic        busy_a;
  logic [2:0]  rd_en_b = '0;
  logic [14:0] rd_addr_b = '0;
  logic [95:0] rd_data_b;
  logic        busy_b;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;

  int checks = 0;
  int errors = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u_dut_a (
    .clk(clk), .reset(rst), .rd_en(rd_en_a), .rd_addr(rd_addr_a),
    .rd_data(rd_data_a), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy_a)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(0)) u_dut_b (
    .clk(clk), .reset(rst), .rd_en(rd_en_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          valid = 1'b0;
  int          clear_left = 0;
  logic        exp_busy = 1'b1;
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic [31:0] exp_a [2];
  logic [31:0] exp_b [3];

  always @(posedge clk) begin
    if (!rst) begin
      valid      = 1'b1;
      clear_left = 32;
      exp_busy   = 1'b1;
      for (int i = 0; i < 32; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
      for (int i = 0; i < 2; i++) exp_a[i] = '0;
      for (int i = 0; i < 3; i++) exp_b[i] = '0;
    end else if (valid && clear_left > 0) begin
      clear_left--;
      exp_busy = (clear_left != 0);
    end else if (valid) begin
      for (int k = 0; k < 2; k++) begin
        if (rd_en_a[k]) begin
          logic [4:0] a;
          a = rd_addr_a[k*5 +: 5];
          if (a == 0) exp_a[k] = '0;
          else if (BYP && wr_en && wr_addr == a) exp_a[k] = wr_data;
          else exp_a[k] = mem_a[a];
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (rd_en_b[k]) begin
          logic [4:0] a;
          a = rd_addr_b[k*5 +: 5];
          if (BYP && wr_en && wr_addr == a) exp_b[k] = wr_data;
          else exp_b[k] = mem_b[a];
        end
      end
      if (wr_en) begin
        if (wr_addr != 0) mem_a[wr_addr] = wr_data;
        mem_b[wr_addr] = wr_data;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (valid) begin
      chk("busy_a", 32'(busy_a), 32'(exp_busy));
      chk("busy_b", 32'(busy_b), 32'(exp_busy));
      for (int k = 0; k < 2; k++)
        chk($sformatf("a_rd%0d", k), rd_data_a[k*32 +: 32], exp_a[k]);
      for (int k = 0; k < 3; k++)
        chk($sformatf("b_rd%0d", k), rd_data_b[k*32 +: 32], exp_b[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en_a = '0; rd_en_b = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle(); wr_en = 1'b1; wr_addr = a; wr_data = d; tick(); wr_en = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] coll_exp;

    // Reset held for 3 edges, then clear sequence length
    rst = 1'b0;
    repeat (3) tick();
    chk("reset_busy", 32'(busy_a), 32'd1);
    chk("reset_rd", rd_data_a[31:0], 32'd0);
    rst = 1'b1;
    count_busy(n);
    chk("clear_len", 32'(n), 32'd32);

    // Every address reads zero after clear
    for (int a = 0; a < 32; a++) begin
      rd_en_a = 2'b11; rd_addr_a = {5'(a), 5'(a)};
      rd_en_b = 3'b111; rd_addr_b = {5'(a), 5'(a), 5'(a)};
      tick();
    end
    idle();

    // Write/read and hold
    wr(5'd5, 32'hDEADBEEF);
    rd_en_a = 2'b11; rd_addr_a = {5'd5, 5'd5};
    tick();
    chk("r5_p0", rd_data_a[31:0], 32'hDEADBEEF);
    chk("r5_p1", rd_data_a[63:32], 32'hDEADBEEF);
    idle(); tick(); tick();
    chk("r5_hold", rd_data_a[63:32], 32'hDEADBEEF);

    // Zero register
    wr(5'd0, 32'h12345678);
    rd_en_a = 2'b01; rd_addr_a = '0; rd_en_b = 3'b001; rd_addr_b = '0;
    tick();
    chk("r0_zero", rd_data_a[31:0], 32'h0);
    chk("r0_nozero", rd_data_b[31:0], 32'h12345678);
    idle();

    // Same-edge collision on r7
    wr(5'd7, 32'h1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h2;
    rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd7};
    tick();
    coll_exp = BYP ? 32'h2 : 32'h1;
    chk("collision", rd_data_a[31:0], coll_exp);
    idle();
    rd_en_a = 2'b01; tick();
    chk("collision_after", rd_data_a[31:0], 32'h2);
    idle();

    // Three ports, three registers, same cycle
    wr(5'd1, 32'h1111_0001);
    wr(5'd2, 32'h2222_0002);
    wr(5'd3, 32'h3333_0003);
    rd_en_b = 3'b111; rd_addr_b = {5'd3, 5'd2, 5'd1};
    tick();
    chk("b_p0_r1", rd_data_b[31:0], 32'h1111_0001);
    chk("b_p1_r2", rd_data_b[63:32], 32'h2222_0002);
    chk("b_p2_r3", rd_data_b[95:64], 32'h3333_0003);
    idle();

    // Mid-operation reset with a write attempted during busy
    wr(5'd3, 32'hAA);
    rst = 1'b0; tick(); rst = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    count_busy(n);
    wr_en = 1'b0;
    chk("reclear_len", 32'(n), 32'd32);
    rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd3}; rd_en_b = 3'b001; rd_addr_b = {10'd0, 5'd3};
    tick();
    chk("r3_cleared_a", rd_data_a[31:0], 32'h0);
    chk("r3_cleared_b", rd_data_b[31:0], 32'h0);
    idle();

    // Randomised traffic with occasional resets and frequent collisions
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 299) != 0);
      wr_en   = 1'($urandom);
      wr_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wr_data = $urandom;
      rd_en_a = 2'($urandom);
      rd_en_b = 3'($urandom);
      for (int k = 0; k < 2; k++)
        rd_addr_a[k*5 +: 5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      for (int k = 0; k < 3; k++)
        rd_addr_b[k*5 +: 5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      tick();
    end
    rst = 1'b1; idle(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
